// File: rtl/picture_crop_ctrl.sv
// Frame-level crop sequencer for the Ethernet-to-DDR video path (gmii_rx_clk domain).
// Optional feature macro: PICTURE_CROP_DROP_CNT_EN adds a saturating drop_cnt output.
module picture_crop_ctrl #(
  parameter int SRC_H  = 800,
  parameter int SRC_V  = 480,
  parameter int CNT_W  = 11,
  parameter int DEF_X0 = 160,
  parameter int DEF_X1 = 640,
  parameter int DEF_Y0 = 104,
  parameter int DEF_Y1 = 376
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             pix_vld_i,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_x0,
  input  logic [CNT_W-1:0] cfg_x1,
  input  logic [CNT_W-1:0] cfg_y0,
  input  logic [CNT_W-1:0] cfg_y1,
  output logic             cfg_err,
  output logic             crop_vld_o,
  output logic             crop_sof_o,
  output logic             crop_eol_o,
  output logic             frame_done_o,
  output logic             frame_abort_o,
  output logic [15:0]      frame_cnt,
  output logic             busy_o
`ifdef PICTURE_CROP_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] x0;
    logic [CNT_W-1:0] x1;
    logic [CNT_W-1:0] y0;
    logic [CNT_W-1:0] y1;
  } win_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(SRC_H - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(SRC_V - 1);
  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(SRC_H);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(SRC_V);
  localparam win_t DEF_WIN = '{x0: CNT_W'(DEF_X0), x1: CNT_W'(DEF_X1),
                               y0: CNT_W'(DEF_Y0), y1: CNT_W'(DEF_Y1)};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  win_t             act_q, act_d, pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             vld_q, vld_d, sof_q, sof_d, eol_q, eol_d;
  logic             done_q, done_d, abort_q, abort_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             cfg_ok, in_win;
`ifdef PICTURE_CROP_DROP_CNT_EN
  logic [15:0]      drop_q, drop_d;
`endif

  assign cfg_ok = (cfg_x0 < cfg_x1) && (cfg_x1 <= H_MAX) &&
                  (cfg_y0 < cfg_y1) && (cfg_y1 <= V_MAX);
  assign in_win = (x_q >= act_q.x0) && (x_q < act_q.x1) &&
                  (y_q >= act_q.y0) && (y_q < act_q.y1);

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    act_d       = act_q;
    pend_d      = pend_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = 1'b0;
    vld_d       = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    // The copy into act_d below reads pend_q, so a coincident cfg_wr lands one frame later.
    if (cfg_wr) begin
      if (cfg_ok) pend_d = '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1};
      else        cfg_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: if (enable) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (frame_start) begin
          state_d = ACTIVE;
          act_d   = pend_q;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ACTIVE: begin
        if (frame_start) begin
          abort_d = 1'b1;
          act_d   = pend_q;
          x_d     = '0;
          y_d     = '0;
        end else if (pix_vld_i) begin
          vld_d = in_win;
          sof_d = in_win && (x_q == act_q.x0) && (y_q == act_q.y0);
          eol_d = in_win && (x_q == act_q.x1 - ONE);
          if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
              y_d         = '0;
              state_d     = DONE;
              done_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              y_d = y_q + ONE;
            end
          end else begin
            x_d = x_q + ONE;
          end
        end
      end
      DONE: state_d = enable ? WAIT_SOF : IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PICTURE_CROP_DROP_CNT_EN
  always_comb begin
    drop_d = drop_q;
    if (pix_vld_i && (state_q != ACTIVE) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end
`endif

  // NOTE: state uses non-blocking assignments only; the window registers are plain flops and
  // take their DEF values in the synchronous reset like every other register.
  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      act_q       <= DEF_WIN;
      pend_q      <= DEF_WIN;
      cfg_err_q   <= 1'b0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
`ifdef PICTURE_CROP_DROP_CNT_EN
      drop_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
      vld_q       <= vld_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef PICTURE_CROP_DROP_CNT_EN
      drop_q      <= drop_d;
`endif
    end
  end

  assign cfg_err       = cfg_err_q;
  assign crop_vld_o    = vld_q;
  assign crop_sof_o    = sof_q;
  assign crop_eol_o    = eol_q;
  assign frame_done_o  = done_q;
  assign frame_abort_o = abort_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy_o        = (state_q == ACTIVE);
`ifdef PICTURE_CROP_DROP_CNT_EN
  assign drop_cnt      = drop_q;
`endif

endmodule

// File: tb/tb_picture_crop_ctrl.sv
// Self-checking bench for picture_crop_ctrl on a reduced 20x12 source frame; a pixel-index
// reference model is compared every cycle, with literal totals pinning the directed frames.
module tb_picture_crop_ctrl;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int W  = 11;
  localparam int X0 = 4;
  localparam int X1 = 16;
  localparam int Y0 = 3;
  localparam int Y1 = 9;

  logic clk = 1'b0;
  logic rst_n, enable, frame_start, pix_vld, cfg_wr;
  logic [W-1:0] cx0, cx1, cy0, cy1;
  logic cfg_err, crop_vld_o, crop_sof_o, crop_eol_o, frame_done_o, frame_abort_o, busy_o;
  logic [15:0] frame_cnt;
`ifdef PICTURE_CROP_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  picture_crop_ctrl #(
    .SRC_H(H), .SRC_V(V), .CNT_W(W),
    .DEF_X0(X0), .DEF_X1(X1), .DEF_Y0(Y0), .DEF_Y1(Y1)
  ) u_dut (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .pix_vld_i(pix_vld), .cfg_wr(cfg_wr),
    .cfg_x0(cx0), .cfg_x1(cx1), .cfg_y0(cy0), .cfg_y1(cy1),
    .cfg_err(cfg_err), .crop_vld_o(crop_vld_o), .crop_sof_o(crop_sof_o),
    .crop_eol_o(crop_eol_o), .frame_done_o(frame_done_o), .frame_abort_o(frame_abort_o),
    .frame_cnt(frame_cnt), .busy_o(busy_o)
`ifdef PICTURE_CROP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame progress is a linear pixel index, window as four integers.
  typedef enum {M_IDLE, M_WAIT, M_ACTIVE, M_DONE} mode_t;
  mode_t m_mode;
  int m_pix, m_frames, m_drop;
  int act[4];
  int pend[4];
  logic e_vld, e_sof, e_eol, e_done, e_abort, e_err, e_busy;
  logic [15:0] e_cnt, e_drop;

  // Observation counters for the directed frames.
  bit cnt_en = 1'b0;
  int cur_pix, n_vld, n_sof, n_eol, n_done, n_abort, n_err, sof_at;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic bit cfg_valid(input int a0, input int a1, input int b0, input int b1);
    return (a0 < a1) && (a1 <= H) && (b0 < b1) && (b1 <= V);
  endfunction

  task automatic model_step();
    bit ok;
    int px, py;
    e_vld = 0; e_sof = 0; e_eol = 0; e_done = 0; e_abort = 0; e_err = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pix = 0; m_frames = 0; m_drop = 0;
      act  = '{X0, X1, Y0, Y1};
      pend = '{X0, X1, Y0, Y1};
    end else begin
      ok = cfg_valid(int'(cx0), int'(cx1), int'(cy0), int'(cy1));
      e_err = cfg_wr && !ok;
      if (pix_vld && m_mode != M_ACTIVE && m_drop < 65535) m_drop++;
      case (m_mode)
        M_IDLE: if (enable) m_mode = M_WAIT;
        M_WAIT: if (frame_start) begin act = pend; m_pix = 0; m_mode = M_ACTIVE; end
        M_ACTIVE: begin
          if (frame_start) begin
            e_abort = 1; m_pix = 0; act = pend;
          end else if (pix_vld) begin
            px = m_pix % H;
            py = m_pix / H;
            e_vld = (px >= act[0]) && (px < act[1]) && (py >= act[2]) && (py < act[3]);
            e_sof = e_vld && px == act[0] && py == act[2];
            e_eol = e_vld && px == act[1] - 1;
            m_pix++;
            if (m_pix == H * V) begin
              m_mode = M_DONE; e_done = 1; m_frames = (m_frames + 1) % 65536;
            end
          end
        end
        M_DONE: m_mode = enable ? M_WAIT : M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      if (cfg_wr && ok) pend = '{int'(cx0), int'(cx1), int'(cy0), int'(cy1)};
    end
    e_busy = (m_mode == M_ACTIVE);
    e_cnt  = 16'(m_frames);
    e_drop = 16'(m_drop);
  endtask

  // Compare process: DUT outputs sampled on the falling edge.
  always @(negedge clk) begin
    vectors++;
    cmp("crop_vld", 16'(crop_vld_o), 16'(e_vld));
    cmp("crop_sof", 16'(crop_sof_o), 16'(e_sof));
    cmp("crop_eol", 16'(crop_eol_o), 16'(e_eol));
    cmp("frame_done", 16'(frame_done_o), 16'(e_done));
    cmp("frame_abort", 16'(frame_abort_o), 16'(e_abort));
    cmp("cfg_err", 16'(cfg_err), 16'(e_err));
    cmp("busy", 16'(busy_o), 16'(e_busy));
    cmp("frame_cnt", frame_cnt, e_cnt);
`ifdef PICTURE_CROP_DROP_CNT_EN
    cmp("drop_cnt", drop_cnt, e_drop);
`endif
  end

  always @(negedge clk) begin
    if (cnt_en) begin
      n_vld   += int'(crop_vld_o);
      n_sof   += int'(crop_sof_o);
      n_eol   += int'(crop_eol_o);
      n_done  += int'(frame_done_o);
      n_abort += int'(frame_abort_o);
      n_err   += int'(cfg_err);
      if (crop_sof_o) sof_at = cur_pix;
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_vld = 0; n_sof = 0; n_eol = 0; n_done = 0; n_abort = 0; n_err = 0; sof_at = -1;
  endtask

  task automatic pixels(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      pix_vld = 1'b1;
      cur_pix = first + i;
      step();
    end
    pix_vld = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_frame();
    pulse_fs();
    pixels(0, H * V);
    step();
    step();
  endtask

  task automatic set_cfg(input int a0, input int a1, input int b0, input int b1);
    cx0 = W'(a0); cx1 = W'(a1); cy0 = W'(b0); cy1 = W'(b1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pix_vld = 1'b0; cfg_wr = 1'b0;
    cur_pix = 0;
    set_cfg(0, 0, 0, 0);
    clear_counts();
    step(); step(); step();
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_busy", int'(busy_o), 0);

    rst_n = 1'b1; enable = 1'b1;
    step(); step();

    // Default window, one full frame.
    clear_counts(); cnt_en = 1'b1;
    run_frame();
    cnt_en = 1'b0;
    check("f1_vld", n_vld, 72);
    check("f1_eol", n_eol, 6);
    check("f1_sof", n_sof, 1);
    check("f1_sof_at", sof_at, 64);
    check("f1_done", n_done, 1);
    check("f1_cnt", int'(frame_cnt), 1);

    // Full-frame window written mid-frame applies only to the next frame.
    clear_counts(); cnt_en = 1'b1;
    pulse_fs();
    pixels(0, 100);
    set_cfg(0, H, 0, V); cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    pixels(100, H * V - 100);
    step(); step();
    check("f2_vld", n_vld, 72);
    clear_counts();
    run_frame();
    check("f3_vld", n_vld, 240);
    check("f3_eol", n_eol, 12);
    check("f3_sof_at", sof_at, 0);
    check("f3_cnt", int'(frame_cnt), 3);

    // Rejected window: cfg_err pulse, previous window kept.
    clear_counts();
    set_cfg(16, 4, 0, 2); cfg_wr = 1'b1; step(); cfg_wr = 1'b0; step();
    check("bad_cfg_err", n_err, 1);
    run_frame();
    check("f4_vld", n_vld, 240);

    // cfg_wr coincident with frame_start: old pending used now, new one next frame.
    clear_counts();
    set_cfg(2, 6, 1, 3); cfg_wr = 1'b1; frame_start = 1'b1; step();
    cfg_wr = 1'b0; frame_start = 1'b0;
    pixels(0, H * V); step(); step();
    check("f5_vld", n_vld, 240);
    clear_counts();
    run_frame();
    check("f6_vld", n_vld, 8);
    check("f6_eol", n_eol, 2);
    check("f6_sof_at", sof_at, 22);
    check("f6_cnt", int'(frame_cnt), 6);

    // Mid-frame abort.
    set_cfg(X0, X1, Y0, Y1); cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    clear_counts();
    pulse_fs();
    pixels(0, 50);
    pulse_fs();
    check("abort_cnt_held", int'(frame_cnt), 6);
    check("abort_busy", int'(busy_o), 1);
    pixels(0, H * V); step(); step();
    check("abort_pulses", n_abort, 1);
    check("f7_vld", n_vld, 72);
    check("f7_cnt", int'(frame_cnt), 7);

    // Pixels while waiting for a frame header are dropped.
    clear_counts();
    pixels(0, 50);
    check("wait_vld", n_vld, 0);
`ifdef PICTURE_CROP_DROP_CNT_EN
    check("wait_drop", int'(drop_cnt), 50);
`endif
    run_frame();

    // enable dropped mid-frame: frame completes, then IDLE ignores frame_start.
    pulse_fs();
    pixels(0, 100);
    enable = 1'b0;
    pixels(100, H * V - 100);
    step(); step();
    check("dis_cnt", int'(frame_cnt), 9);
    check("dis_busy", int'(busy_o), 0);
    clear_counts();
    pulse_fs();
    pixels(0, 20);
    check("idle_vld", n_vld, 0);
    check("idle_busy", int'(busy_o), 0);
    cnt_en = 1'b0;
    enable = 1'b1;
    step(); step();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(0, 15) != 0);
      frame_start = ($urandom_range(0, 299) == 0);
      pix_vld     = ($urandom_range(0, 3) != 0);
      cfg_wr      = ($urandom_range(0, 49) == 0);
      set_cfg($urandom_range(0, 22), $urandom_range(0, 22),
              $urandom_range(0, 14), $urandom_range(0, 14));
      step();
    end
    frame_start = 1'b0; pix_vld = 1'b0; cfg_wr = 1'b0; enable = 1'b1;
    step(); step();

    // Reset asserted mid-frame.
    pulse_fs();
    pixels(0, 30);
    rst_n = 1'b0;
    step();
    check("rst_mid_vld", int'(crop_vld_o), 0);
    check("rst_mid_cnt", int'(frame_cnt), 0);
    check("rst_mid_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
